// File: rtl/kmeans_pkg.sv
// Shared widths and state encoding for the k-means accelerator.
// Used by the classification and centroid-update stages.
package kmeans_pkg;

    localparam int CENTROID_NUM = 8;
    localparam int CORD_NUM     = 7;
    localparam int ACCUM_CORD_W = 22;
    localparam int CORD_W       = 13;
    localparam int CNT_W        = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        WRITE,
        DONE
    } means_state_t;

endpackage

// File: rtl/new_means_calc_serial_divider.sv
// Bit-serial restoring divider: one quotient bit per step, MSB first.
// The quotient output is saturated to the centroid coordinate width.
module serial_divider
    import kmeans_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    step,
    input  logic [ACCUM_CORD_W-1:0] dividend,
    input  logic [CNT_W-1:0]        divisor,
    output logic [CORD_W-1:0]       quotient
);

    logic [ACCUM_CORD_W-1:0] dvd_q;
    logic [ACCUM_CORD_W-1:0] quo_q;
    logic [ACCUM_CORD_W-1:0] quo_nxt;
    logic [CNT_W-1:0]        dvs_q;
    logic [CNT_W-1:0]        rem_q;
    logic [CNT_W-1:0]        rem_nxt;
    logic [CNT_W:0]          shifted;
    logic                    fits;

    // The remainder never reaches the divisor, so after subtraction
    // (or when nothing is subtracted) it fits back into CNT_W bits.
    always_comb begin
        shifted = {rem_q, dvd_q[ACCUM_CORD_W-1]};
        fits    = shifted >= {1'b0, dvs_q};
        rem_nxt = fits ? CNT_W'(shifted - {1'b0, dvs_q})
                       : shifted[CNT_W-1:0];
        quo_nxt = {quo_q[ACCUM_CORD_W-2:0], fits};
    end

    // Reflects the step in progress so the final value is ready
    // at the edge that completes the last iteration.
    assign quotient = (|quo_nxt[ACCUM_CORD_W-1:CORD_W])
                    ? '1 : quo_nxt[CORD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (init) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
        end else if (step) begin
            dvd_q <= {dvd_q[ACCUM_CORD_W-2:0], 1'b0};
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/new_means_calc.sv
// Centroid update: divides each cluster accumulator by its point
// count and writes the result back over the core write path.
module new_means_calc
    import kmeans_pkg::*;
#(
    parameter int centroid_num     = CENTROID_NUM,
    parameter int cordinate_num    = CORD_NUM,
    parameter int accum_cord_width = ACCUM_CORD_W,
    parameter int cordinate_width  = CORD_W,
    parameter int accum_width      = cordinate_num * accum_cord_width,
    parameter int dataWidth        = cordinate_num * cordinate_width,
    parameter int count_width      = CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [accum_width-1:0]  accum_1,
    input  logic [accum_width-1:0]  accum_2,
    input  logic [accum_width-1:0]  accum_3,
    input  logic [accum_width-1:0]  accum_4,
    input  logic [accum_width-1:0]  accum_5,
    input  logic [accum_width-1:0]  accum_6,
    input  logic [accum_width-1:0]  accum_7,
    input  logic [accum_width-1:0]  accum_8,
    input  logic [count_width-1:0]  cnt_1,
    input  logic [count_width-1:0]  cnt_2,
    input  logic [count_width-1:0]  cnt_3,
    input  logic [count_width-1:0]  cnt_4,
    input  logic [count_width-1:0]  cnt_5,
    input  logic [count_width-1:0]  cnt_6,
    input  logic [count_width-1:0]  cnt_7,
    input  logic [count_width-1:0]  cnt_8,
    output logic [dataWidth-1:0]    data_to_core,
    output logic [centroid_num-1:0] centroid_en,
    output logic                    busy,
    output logic                    done
);

    localparam logic [4:0] LAST_ITER = 5'(accum_cord_width - 1);

    means_state_t             state;
    means_state_t             nxt;
    logic [2:0]               idx;
    logic [4:0]               iter;
    logic [accum_width-1:0]   sel_accum;
    logic [count_width-1:0]   sel_cnt;
    logic [dataWidth-1:0]     quot;
    logic                     last_idx;
    logic                     last_iter;
    logic                     empty;

    always_comb begin
        sel_accum = accum_8;
        sel_cnt   = cnt_8;
        case (idx)
            3'd0: begin sel_accum = accum_1; sel_cnt = cnt_1; end
            3'd1: begin sel_accum = accum_2; sel_cnt = cnt_2; end
            3'd2: begin sel_accum = accum_3; sel_cnt = cnt_3; end
            3'd3: begin sel_accum = accum_4; sel_cnt = cnt_4; end
            3'd4: begin sel_accum = accum_5; sel_cnt = cnt_5; end
            3'd5: begin sel_accum = accum_6; sel_cnt = cnt_6; end
            3'd6: begin sel_accum = accum_7; sel_cnt = cnt_7; end
            default: ;
        endcase
    end

    assign last_idx  = idx == 3'd7;
    assign last_iter = iter == LAST_ITER;
    assign empty     = sel_cnt == '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = LOAD;
            LOAD:  nxt = empty ? (last_idx ? DONE : LOAD) : DIV;
            DIV:   if (last_iter) nxt = WRITE;
            WRITE: nxt = last_idx ? DONE : LOAD;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            iter         <= '0;
            data_to_core <= '0;
            centroid_en  <= '0;
        end else begin
            state       <= nxt;
            centroid_en <= '0;
            case (state)
                IDLE: idx <= '0;
                LOAD: begin
                    iter <= '0;
                    if (empty) idx <= idx + 3'd1;
                end
                DIV: begin
                    iter <= iter + 5'd1;
                    if (last_iter) begin
                        data_to_core <= quot;
                        centroid_en  <= centroid_num'(1) << idx;
                    end
                end
                WRITE: idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    for (genvar j = 0; j < cordinate_num; j++) begin : g_div
        serial_divider u_div (
            .clk      (clk),
            .rst      (rst),
            .init     (state == LOAD),
            .step     (state == DIV),
            .dividend (sel_accum[j*accum_cord_width +: accum_cord_width]),
            .divisor  (sel_cnt),
            .quotient (quot[j*cordinate_width +: cordinate_width])
        );
    end

endmodule
